// File: rtl/io_handshake_sequencer_if.sv
// Handshake bundle between the control core / board pins and io_handshake_sequencer.
// master drives the decoded flags and raw buttons; slave is the sequencer itself.
interface io_handshake_sequencer_if;
  logic       is_input;
  logic       is_output;
  logic       raw_confirm;
  logic       raw_continue;
  logic       confirmation;
  logic       continue_button;
  logic       waiting;
  logic [1:0] fsm_state;

  modport master (
    output is_input, is_output, raw_confirm, raw_continue,
    input  confirmation, continue_button, waiting, fsm_state
  );

  modport slave (
    input  is_input, is_output, raw_confirm, raw_continue,
    output confirmation, continue_button, waiting, fsm_state
  );
endinterface

// File: rtl/io_handshake_sequencer.sv
// Converts board buttons into single-cycle confirmation/continue strobes for I/O and PAUSE.
// Define IO_AUTO_CONFIRM_EN to bypass the buttons and strobe automatically on every request.
module io_handshake_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input logic                    clock,
  input logic                    reset,
  io_handshake_sequencer_if.slave hs
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_REL   = 2'd1,
    WAIT_PRESS = 2'd2,
    FIRE       = 2'd3
  } state_t;

  typedef enum logic {
    KIND_IO    = 1'b0,
    KIND_PAUSE = 1'b1
  } kind_t;

  // Bit 0 is the confirm button, bit 1 the continue button.
  logic [1:0] raw;
  logic [1:0] deb;

  assign raw = {hs.raw_continue, hs.raw_confirm};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic             s1;
    logic             s2;
    logic             lvl;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
      if (!reset) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        lvl <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= raw[g];
        s2 <= s1;
        // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
        if (s2 == lvl) begin
          cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign deb[g] = lvl;
  end

  logic   req;
  kind_t  kind_now;
  kind_t  kind_q;
  logic   btn_now;
  logic   btn_lat;
  logic   abort;

  assign req      = hs.is_input | hs.is_output;
  assign kind_now = (hs.is_input & hs.is_output) ? KIND_PAUSE : KIND_IO;
  assign btn_now  = (kind_now == KIND_PAUSE) ? deb[1] : deb[0];
  assign btn_lat  = (kind_q   == KIND_PAUSE) ? deb[1] : deb[0];
  assign abort    = !req || (kind_now != kind_q);

  state_t state;
  logic   confirmation_q;
  logic   continue_q;
  logic   waiting_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      kind_q         <= KIND_IO;
      confirmation_q <= 1'b0;
      continue_q     <= 1'b0;
      waiting_q      <= 1'b0;
    end else begin
      confirmation_q <= 1'b0;
      continue_q     <= 1'b0;
      case (state)
`ifdef IO_AUTO_CONFIRM_EN
        IDLE: begin
          if (req) begin
            kind_q         <= kind_now;
            state          <= FIRE;
            confirmation_q <= (kind_now == KIND_IO);
            continue_q     <= (kind_now == KIND_PAUSE);
          end
        end
        // Returning to IDLE forces one idle cycle between back-to-back strobes.
        default: state <= IDLE;
`else
        IDLE: begin
          if (req) begin
            kind_q    <= kind_now;
            waiting_q <= 1'b1;
            state     <= btn_now ? WAIT_REL : WAIT_PRESS;
          end
        end
        WAIT_REL: begin
          if (abort) begin
            state     <= IDLE;
            waiting_q <= 1'b0;
          end else if (!btn_lat) begin
            state <= WAIT_PRESS;
          end
        end
        WAIT_PRESS: begin
          if (abort) begin
            state     <= IDLE;
            waiting_q <= 1'b0;
          end else if (btn_lat) begin
            state          <= FIRE;
            waiting_q      <= 1'b0;
            confirmation_q <= (kind_q == KIND_IO);
            continue_q     <= (kind_q == KIND_PAUSE);
          end
        end
        // The core retires the instruction now; a held button must be released
        // before the next I/O instruction can be confirmed.
        FIRE: begin
          state     <= WAIT_REL;
          waiting_q <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          waiting_q <= 1'b0;
        end
`endif
      endcase
    end
  end

  assign hs.confirmation    = confirmation_q;
  assign hs.continue_button = continue_q;
  assign hs.waiting         = waiting_q;
  assign hs.fsm_state       = state;

endmodule

// File: tb/tb_io_handshake_sequencer.sv
// Self-checking bench for io_handshake_sequencer with DEBOUNCE_CYCLES=4.
// Expected strobes are queued with their cycle when buttons are driven and popped as they appear.
module tb_io_handshake_sequencer;

  localparam int D   = 4;
  localparam int LAT = D + 3;

  logic clock = 1'b0;
  logic reset;

  io_handshake_sequencer_if bus ();

  io_handshake_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .hs   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int   cyc;
    logic cont;
  } exp_t;

  typedef struct {
    logic is_input;
    logic is_output;
    logic press_conf;
    logic press_cont;
    int   exp_strobe;  // 0 none, 1 confirmation, 2 continue_button
    int   exp_state;   // fsm_state after the press has had time to act
  } vec_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_strobe(input int at, input logic cont);
    exp_t e;
    e.cyc  = at;
    e.cont = cont;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (bus.confirmation || bus.continue_button) begin
      check("strobe_vs_waiting", int'(bus.waiting), 0);
      if (sb.size() == 0) begin
        check("unexpected_strobe", cyc, -1);
      end else begin
        e = sb.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_which", int'(bus.continue_button) * 2 + int'(bus.confirmation),
              e.cont ? 2 : 1);
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic in_f, input logic out_f, input logic conf, input logic cont);
    bus.is_input     = in_f;
    bus.is_output    = out_f;
    bus.raw_confirm  = conf;
    bus.raw_continue = cont;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 2};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 0, 2};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1, 1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1};

    // Reset held with both buttons pressed.
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    ticks(3);
    check("reset_confirmation", int'(bus.confirmation), 0);
    check("reset_continue", int'(bus.continue_button), 0);
    check("reset_waiting", int'(bus.waiting), 0);
    check("reset_state", int'(bus.fsm_state), 0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(D + 4);

`ifdef IO_AUTO_CONFIRM_EN
    begin
      int base;
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      base = cyc;
      for (int k = 0; k < 5; k++) expect_strobe(base + 1 + 2 * k, 1'b0);
      ticks(10);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      ticks(3);
      check("auto_idle", int'(bus.fsm_state), 0);
      check("auto_waiting", int'(bus.waiting), 0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      expect_strobe(cyc + 1, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      ticks(3);
      check("auto_pause_idle", int'(bus.fsm_state), 0);
    end
`else
    // OUTPUT with a fresh press.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("out_wait_press", int'(bus.fsm_state), 2);
    check("out_waiting", int'(bus.waiting), 1);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    expect_strobe(cyc + LAT, 1'b0);
    ticks(LAT);
    check("out_fire_state", int'(bus.fsm_state), 3);
    check("out_fire_waiting", int'(bus.waiting), 0);
    check("out_fire_strobe", int'(bus.confirmation), 1);
    tick();
    check("out_after_fire", int'(bus.fsm_state), 1);
    check("out_after_waiting", int'(bus.waiting), 1);

    // Held button across the next OUTPUT, then a too-short release.
    ticks(10);
    check("held_wait_rel", int'(bus.fsm_state), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(10);
    check("short_release", int'(bus.fsm_state), 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(D + 4);
    check("full_release", int'(bus.fsm_state), 2);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    expect_strobe(cyc + LAT, 1'b0);
    ticks(LAT + 2);
    check("second_strobe_rel", int'(bus.fsm_state), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(D + 4);
    check("out_done_idle", int'(bus.fsm_state), 0);

    // PAUSE ignores confirm, fires on continue.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("pause_wait_press", int'(bus.fsm_state), 2);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(12);
    check("pause_ignores_confirm", int'(bus.fsm_state), 2);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    expect_strobe(cyc + LAT, 1'b1);
    ticks(LAT + 1);
    check("pause_after_fire", int'(bus.fsm_state), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    ticks(D + 4);

    // Glitch, kind change, dropped request, reset mid-wait.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("glitch_arm", int'(bus.fsm_state), 2);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    ticks(3);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(10);
    check("glitch_ignored", int'(bus.fsm_state), 2);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check("kind_change_abort", int'(bus.fsm_state), 0);
    tick();
    check("kind_change_rearm", int'(bus.fsm_state), 2);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("drop_req_idle", int'(bus.fsm_state), 0);
    check("drop_req_waiting", int'(bus.waiting), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    ticks(3);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2);
    check("midwait_reset_state", int'(bus.fsm_state), 0);
    check("midwait_reset_waiting", int'(bus.waiting), 0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b0);
    ticks(D + 4);
    check("midwait_reset_after", int'(bus.fsm_state), 0);

    // Table of request/button combinations.
    foreach (vecs[i]) begin
      drive(vecs[i].is_input, vecs[i].is_output, 1'b0, 1'b0);
      tick();
      check("vec_arm", int'(bus.fsm_state), (vecs[i].is_input | vecs[i].is_output) ? 2 : 0);
      drive(vecs[i].is_input, vecs[i].is_output, vecs[i].press_conf, vecs[i].press_cont);
      if (vecs[i].exp_strobe != 0) expect_strobe(cyc + LAT, vecs[i].exp_strobe == 2);
      ticks(12);
      check("vec_final", int'(bus.fsm_state), vecs[i].exp_state);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      ticks(D + 4);
    end
`endif

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
